// File: rtl/rb_dump_sequencer_if.sv
// Handshake bundle between the register-dump sequencer, the register bank
// debug read port and the UART transmitter.
interface rb_dump_sequencer_if #(
    parameter int DATA_SIZE = 32,
    parameter int REG_SIZE  = 5,
    parameter int BYTE_SIZE = 8
);
    logic                 i_start;
    logic [DATA_SIZE-1:0] i_rb_data;
    logic                 i_tx_done;
    logic                 o_rb_read_enable;
    logic [REG_SIZE-1:0]  o_rb_read_addr;
    logic                 o_tx_start;
    logic [BYTE_SIZE-1:0] o_tx_data;
    logic                 o_busy;
    logic                 o_done;

    modport master (
        input  i_start, i_rb_data, i_tx_done,
        output o_rb_read_enable, o_rb_read_addr, o_tx_start, o_tx_data, o_busy, o_done
    );

    modport slave (
        output i_start, i_rb_data, i_tx_done,
        input  o_rb_read_enable, o_rb_read_addr, o_tx_start, o_tx_data, o_busy, o_done
    );
endinterface

// File: rtl/rb_dump_sequencer.sv
// Walks the register bank debug port and streams every word, MSB byte first, to the UART TX.
// Optional trailing XOR checksum byte: define RB_DUMP_CHECKSUM_EN.
module rb_dump_sequencer #(
    parameter int DATA_SIZE = 32,
    parameter int REG_SIZE  = 5,
    parameter int BYTE_SIZE = 8,
    parameter int NUM_REGS  = 32
) (
    input  logic                i_clock,
    input  logic                i_reset,
    rb_dump_sequencer_if.master bus
);
    localparam int NUM_BYTES = DATA_SIZE / BYTE_SIZE;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [REG_SIZE-1:0] LAST_ADDR = REG_SIZE'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0]    LAST_BYTE = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_CAP   = 3'd2,
        SEND     = 3'd3,
        WAIT_TX  = 3'd4,
        FINISH   = 3'd5
`ifdef RB_DUMP_CHECKSUM_EN
        ,
        CHK_SEND = 3'd6,
        CHK_WAIT = 3'd7
`endif
    } state_t;

    function automatic logic [BYTE_SIZE-1:0] top_byte(input logic [DATA_SIZE-1:0] word);
        return word[DATA_SIZE-1 -: BYTE_SIZE];
    endfunction

    state_t               state_r, state_nxt_s;
    logic [REG_SIZE-1:0]  addr_r, addr_nxt_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
    logic [DATA_SIZE-1:0] shift_r, shift_nxt_s;
`ifdef RB_DUMP_CHECKSUM_EN
    logic [BYTE_SIZE-1:0] chk_r, chk_nxt_s;
`endif
    logic                 rd_en_r, rd_en_nxt_s;
    logic                 tx_start_r, tx_start_nxt_s;
    logic [BYTE_SIZE-1:0] tx_data_r, tx_data_nxt_s;
    logic                 busy_r, busy_nxt_s;
    logic                 done_r, done_nxt_s;

    // Next-state, datapath updates and next output values.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        cnt_nxt_s   = cnt_r;
        shift_nxt_s = shift_r;
`ifdef RB_DUMP_CHECKSUM_EN
        chk_nxt_s   = chk_r;
`endif
        case (state_r)
            IDLE: begin
`ifdef RB_DUMP_CHECKSUM_EN
                chk_nxt_s = {BYTE_SIZE{1'b0}};
`endif
                if (bus.i_start) begin
                    state_nxt_s = RD_REQ;
                    addr_nxt_s  = {REG_SIZE{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_REQ: state_nxt_s = RD_CAP;
            RD_CAP: begin
                shift_nxt_s = bus.i_rb_data;
                cnt_nxt_s   = {CNT_W{1'b0}};
                state_nxt_s = SEND;
            end
            SEND: state_nxt_s = WAIT_TX;
            WAIT_TX: begin
                if (bus.i_tx_done) begin
`ifdef RB_DUMP_CHECKSUM_EN
                    chk_nxt_s = chk_r ^ top_byte(shift_r);
`endif
                    if (cnt_r != LAST_BYTE) begin
                        shift_nxt_s = shift_r << BYTE_SIZE;
                        cnt_nxt_s   = cnt_r + CNT_W'(1);
                        state_nxt_s = SEND;
                    end else if (addr_r != LAST_ADDR) begin
                        addr_nxt_s  = addr_r + REG_SIZE'(1);
                        state_nxt_s = RD_REQ;
                    end else begin
`ifdef RB_DUMP_CHECKSUM_EN
                        state_nxt_s = CHK_SEND;
`else
                        state_nxt_s = FINISH;
`endif
                    end
                end else begin
                    state_nxt_s = WAIT_TX;
                end
            end
            FINISH: begin
                addr_nxt_s  = {REG_SIZE{1'b0}};
                state_nxt_s = IDLE;
            end
`ifdef RB_DUMP_CHECKSUM_EN
            CHK_SEND: state_nxt_s = CHK_WAIT;
            CHK_WAIT: begin
                if (bus.i_tx_done) begin
                    state_nxt_s = FINISH;
                end else begin
                    state_nxt_s = CHK_WAIT;
                end
            end
`endif
            default: state_nxt_s = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered without adding latency.
        rd_en_nxt_s    = (state_nxt_s == RD_REQ);
        busy_nxt_s     = (state_nxt_s != IDLE);
        done_nxt_s     = (state_nxt_s == FINISH);
        tx_start_nxt_s = 1'b0;
        tx_data_nxt_s  = {BYTE_SIZE{1'b0}};
        case (state_nxt_s)
            SEND: begin
                tx_start_nxt_s = 1'b1;
                tx_data_nxt_s  = top_byte(shift_nxt_s);
            end
            WAIT_TX: tx_data_nxt_s = top_byte(shift_nxt_s);
`ifdef RB_DUMP_CHECKSUM_EN
            CHK_SEND: begin
                tx_start_nxt_s = 1'b1;
                tx_data_nxt_s  = chk_nxt_s;
            end
            CHK_WAIT: tx_data_nxt_s = chk_nxt_s;
`endif
            default: tx_data_nxt_s = {BYTE_SIZE{1'b0}};
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r    <= IDLE;
            addr_r     <= {REG_SIZE{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            shift_r    <= {DATA_SIZE{1'b0}};
`ifdef RB_DUMP_CHECKSUM_EN
            chk_r      <= {BYTE_SIZE{1'b0}};
`endif
            rd_en_r    <= 1'b0;
            tx_start_r <= 1'b0;
            tx_data_r  <= {BYTE_SIZE{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            addr_r     <= addr_nxt_s;
            cnt_r      <= cnt_nxt_s;
            shift_r    <= shift_nxt_s;
`ifdef RB_DUMP_CHECKSUM_EN
            chk_r      <= chk_nxt_s;
`endif
            rd_en_r    <= rd_en_nxt_s;
            tx_start_r <= tx_start_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign bus.o_rb_read_enable = rd_en_r;
    assign bus.o_rb_read_addr   = addr_r;
    assign bus.o_tx_start       = tx_start_r;
    assign bus.o_tx_data        = tx_data_r;
    assign bus.o_busy           = busy_r;
    assign bus.o_done           = done_r;
endmodule

// File: tb/tb_rb_dump_sequencer.sv
// Directed/randomised bench for rb_dump_sequencer with a byte-stream reference model.
module tb_rb_dump_sequencer;
    localparam int NR = 32;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rb_dump_sequencer_if bus ();
    rb_dump_sequencer dut (.i_clock(clk), .i_reset(rst), .bus(bus));

    logic [31:0] bank [NR];
    logic [31:0] rb_q = 32'h0;
    logic        tx_force = 1'b0;
    logic        tx_auto = 1'b0;
    assign bus.i_rb_data = rb_q;
    assign bus.i_tx_done = tx_force | tx_auto;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int   tests = 0, fails = 0;
    int   done_cnt = 0, stable_err = 0, wait_cnt = 0;
    logic inflight = 1'b0;
    logic [7:0] held = 8'h0;

    // Register bank debug port: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.o_rb_read_enable) rb_q <= bank[bus.o_rb_read_addr];
    end

    // UART TX model: captures each byte, answers after a random delay, checks data hold.
    always @(negedge clk) begin
        tx_auto = 1'b0;
        if (rst) begin
            inflight = 1'b0;
        end else if (bus.o_tx_start) begin
            rx_q.push_back(bus.o_tx_data);
            held     = bus.o_tx_data;
            inflight = 1'b1;
            wait_cnt = int'($urandom_range(1, 6));
        end else if (inflight) begin
            if (bus.o_tx_data !== held) stable_err++;
            if (wait_cnt <= 1) begin
                tx_auto  = 1'b1;
                inflight = 1'b0;
            end else begin
                wait_cnt--;
            end
        end
        if (bus.o_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Expected byte stream: every word big-endian, optionally followed by the XOR of all bytes.
    task automatic build_ref();
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h0;
        exp_q.delete();
        for (int k = 0; k < NR; k++) begin
            for (int j = 0; j < NB; j++) begin
                b = 8'((bank[k] >> (8 * (NB - 1 - j))) & 32'hFF);
                exp_q.push_back(b);
                x = x ^ b;
            end
        end
`ifdef RB_DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'h0);
        chk({tag, "_outs"}, {26'h0, bus.o_rb_read_enable, bus.o_tx_start, bus.o_done,
                             bus.o_tx_data != 8'h0, bus.o_rb_read_addr != 5'h0, 1'b0}, 32'h0);
    endtask

    task automatic check_first_strobe(input string tag);
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk({tag, "_rden"}, 32'(bus.o_rb_read_enable), 32'h1);
        chk({tag, "_addr"}, 32'(bus.o_rb_read_addr), 32'h0);
        step();
        chk({tag, "_nostrobe"}, 32'(bus.o_tx_start), 32'h0);
        step();
        chk({tag, "_strobe"}, 32'(bus.o_tx_start), 32'h1);
        chk({tag, "_byte0"}, 32'(bus.o_tx_data), {24'h0, exp_q[0]});
    endtask

    task automatic wait_done(input string tag, input bit noise);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 6000 && !seen; c++) begin
            step();
            if (bus.o_done) begin
                seen = 1'b1;
            end else if (noise) begin
                bus.i_start = ($urandom_range(0, 5) == 0);
                tx_force    = bus.o_tx_start && ($urandom_range(0, 1) == 1);
            end
        end
        bus.i_start = 1'b0;
        tx_force    = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'h1);
        step();
        chk({tag, "_busy_after"}, 32'(bus.o_busy), 32'h0);
    endtask

    task automatic check_stream(input string tag, input int done_base);
        chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) chk($sformatf("%s_byte%0d", tag, i), {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
        end
        chk({tag, "_ndone"}, 32'(done_cnt - done_base), 32'h1);
        chk({tag, "_hold"}, 32'(stable_err), 32'h0);
    endtask

    initial begin
        int base;
        bit hit;
        bus.i_start = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        rst = 1'b0;

        // Idle with i_tx_done toggling: nothing may move.
        for (int i = 0; i < 10; i++) begin
            tx_force = ~tx_force;
            step();
            check_idle_outputs("idle");
        end
        tx_force = 1'b0;
        chk("idle_no_strobe", 32'(rx_q.size()), 32'h0);

        // Dump of the patterned bank.
        for (int k = 0; k < NR; k++) bank[k] = 32'h11223300 + 32'(k);
        build_ref();
        rx_q.delete();
        base = done_cnt;
        check_first_strobe("pat");
        wait_done("pat", 1'b0);
        check_stream("pat", base);

        // Random bank with start pulses and stray i_tx_done during SEND.
        for (int k = 0; k < NR; k++) bank[k] = $urandom;
        build_ref();
        rx_q.delete();
        base = done_cnt;
        bus.i_start = 1'b1;
        step();
        wait_done("noise", 1'b1);
        check_stream("noise", base);

        // Abort by reset after byte 50, then restart from address 0.
        for (int k = 0; k < NR; k++) bank[k] = 32'h11223300 + 32'(k);
        build_ref();
        rx_q.delete();
        base = done_cnt;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 3000 && !hit; c++) begin
            step();
            hit = (rx_q.size() >= 50);
        end
        chk("abort_reach50", 32'(hit), 32'h1);
        rst = 1'b1;
        step();
        check_idle_outputs("abort_rst");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("abort_no_done", 32'(done_cnt - base), 32'h0);
        chk("abort_no_more", 32'(rx_q.size()), 32'd50);
        rx_q.delete();
        check_first_strobe("restart");
        wait_done("restart", 1'b0);
        check_stream("restart", base);

        // Uniform bank: checksum byte (when present) cancels to zero.
        for (int k = 0; k < NR; k++) bank[k] = 32'hA5A5A5A5;
        build_ref();
        rx_q.delete();
        base = done_cnt;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        wait_done("a5", 1'b0);
        check_stream("a5", base);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rb_dump_sequencer.md
Name: rb_dump_sequencer

Overview:
- Debug-unit controller that sequences read-out of the 32-entry register bank in ID and streams the contents to the UART transmitter.
- On a start pulse it walks register addresses 0..NUM_REGS-1 through the bank's debug read port and captures each 32-bit word.
- Each word is sent as DATA_SIZE/BYTE_SIZE bytes over a start/done handshake with the UART TX.
- Sits between the debug unit FSM and the register bank debug port; owns the bank read port for the whole dump.

Parameters:
DATA_SIZE, 32, register bank word width (multiple of BYTE_SIZE)
REG_SIZE, 5, register address width
BYTE_SIZE, 8, UART byte width
NUM_REGS, 32, registers dumped (1..2^REG_SIZE)

Ports:
i_clock  input  1  clock, rising edge
i_reset  input  1  synchronous, active-high reset
i_start  input  1  dump request, sampled only in IDLE
i_rb_data  input  DATA_SIZE  register bank debug read data, valid the cycle after o_rb_read_enable
i_tx_done  input  1  UART TX byte-complete pulse
o_rb_read_enable  output  1  register bank debug read strobe
o_rb_read_addr  output  REG_SIZE  register bank debug read address
o_tx_start  output  1  one-cycle UART TX start strobe
o_tx_data  output  BYTE_SIZE  byte to transmit, held stable from o_tx_start until i_tx_done
o_busy  output  1  high in every state except IDLE
o_done  output  1  one-cycle pulse when dump completes

Behaviour:
- Reset, synchronous, active-high: state=IDLE, addr=0, byte_cnt=0, shift register=0.
  - All outputs 0 after reset.
  - Reset wins over any simultaneous input.
  - Reset mid-dump aborts with no o_done pulse.
- States: IDLE, RD_REQ, RD_CAP, SEND, WAIT_TX, FINISH.
- IDLE: i_start=1 goes to RD_REQ with addr=0; otherwise stay.
- RD_REQ: o_rb_read_enable=1, o_rb_read_addr=addr for exactly one cycle; go to RD_CAP.
- RD_CAP: latch i_rb_data into the shift register, byte_cnt=0; go to SEND.
- SEND: o_tx_start=1 for one cycle; o_tx_data = shift register MSB byte (big-endian, byte [31:24] first); go to WAIT_TX.
- WAIT_TX: hold o_tx_data; wait for i_tx_done.
  - On i_tx_done with byte_cnt < DATA_SIZE/BYTE_SIZE-1: shift register left by BYTE_SIZE, byte_cnt+1, go to SEND.
  - On i_tx_done with last byte and addr < NUM_REGS-1: addr+1, go to RD_REQ.
  - On i_tx_done with last byte and addr = NUM_REGS-1: go to FINISH.
- FINISH: o_done=1 for one cycle, addr=0; go to IDLE.
- o_rb_read_addr holds addr in all states; it does not wrap, and the dump ends at NUM_REGS-1.
- i_start outside IDLE is ignored; no queuing.
- i_tx_done outside WAIT_TX is ignored.
- i_tx_done arriving in the same cycle as o_tx_start is not accepted, because the state is SEND, not WAIT_TX.
- Latency, start to first o_tx_start: 3 cycles (IDLE→RD_REQ→RD_CAP→SEND).
- Total bytes per dump: NUM_REGS*DATA_SIZE/BYTE_SIZE = 128 at defaults.

Optional Feature:
RB_DUMP_CHECKSUM_EN
- Defined: an extra state CHK_SEND/CHK_WAIT follows the last data byte.
  - Sends one byte equal to the XOR of all transmitted data bytes, using the same start/done handshake.
  - FINISH follows the checksum's i_tx_done.
  - The running XOR clears in IDLE and on reset.
- Undefined: no checksum byte; FINISH follows the last data byte directly; the XOR logic is absent.

Test Plan:
- Reset, then idle 10 cycles with i_tx_done toggling → all outputs 0, no o_tx_start.
- Bank preloaded with reg[k]=0x11223300+k, i_start pulse, TX model answers i_tx_done 5 cycles after each start → 128 bytes received in order 11,22,33,00,11,22,33,01,…,11,22,33,1F; one o_done pulse; o_busy low afterwards.
- Start-to-first-strobe timing → o_rb_read_enable with addr=0 one cycle after i_start; o_tx_start with data 0x11 three cycles after i_start.
- i_start pulsed repeatedly mid-dump, plus a stray i_tx_done while in SEND → byte count and order unchanged; still exactly 128 bytes.
- i_reset asserted after byte 50 → next cycle state IDLE, outputs 0, no o_done; a fresh i_start restarts from addr 0, first byte 0x11.
- With RB_DUMP_CHECKSUM_EN defined, bank all 0xA5A5A5A5 → 129 bytes; last byte 0x00 (even count of 0xA5); o_done after its i_tx_done.
